// File: rtl/corral_host.sv
// Player-side host for the Corral game core: issues one move per frame, captures the
// cowboy/horse response nibbles and end-of-frame status, and hands them out via valid/ready.
module corral_host #(
   parameter int RESP_LATENCY = 1,
   parameter int TIMEOUT      = 15
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_move,
   output logic       dev_enter,
   output logic [2:0] dev_move,
   input  logic [3:0] dev_data,
   input  logic       dev_ready,
   input  logic       dev_gameover,
   input  logic       dev_lostwon,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [3:0] res_cowboy,
   output logic [3:0] res_horse,
   output logic       res_gameover,
   output logic       res_lostwon,
   output logic       res_timeout,
   output logic [7:0] move_count
);

   typedef enum logic [2:0] {IDLE, SEND, LAT, CAP_H, WAIT_RDY, RESULT} state_t;

   localparam logic [2:0] LAT_LOAD = 3'(RESP_LATENCY - 1);
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [2:0] move_q, move_d;
   logic [2:0] lat_cnt_q, lat_cnt_d;
   logic [7:0] to_cnt_q, to_cnt_d;
   logic [3:0] cowboy_q, cowboy_d;
   logic [3:0] horse_q, horse_d;
   logic       gameover_q, gameover_d;
   logic       lostwon_q, lostwon_d;
   logic       timeout_q, timeout_d;
   logic [7:0] count_q, count_d;
   logic       game_over_q, game_over_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         move_q      <= '0;
         lat_cnt_q   <= '0;
         to_cnt_q    <= '0;
         cowboy_q    <= '0;
         horse_q     <= '0;
         gameover_q  <= 1'b0;
         lostwon_q   <= 1'b0;
         timeout_q   <= 1'b0;
         count_q     <= '0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         move_q      <= move_d;
         lat_cnt_q   <= lat_cnt_d;
         to_cnt_q    <= to_cnt_d;
         cowboy_q    <= cowboy_d;
         horse_q     <= horse_d;
         gameover_q  <= gameover_d;
         lostwon_q   <= lostwon_d;
         timeout_q   <= timeout_d;
         count_q     <= count_d;
         game_over_q <= game_over_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      move_d      = move_q;
      lat_cnt_d   = lat_cnt_q;
      to_cnt_d    = to_cnt_q;
      cowboy_d    = cowboy_q;
      horse_d     = horse_q;
      gameover_d  = gameover_q;
      lostwon_d   = lostwon_q;
      timeout_d   = timeout_q;
      count_d     = count_q;
      game_over_d = game_over_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               move_d  = cmd_move;
               state_d = SEND;
            end
         end
         SEND: begin
            lat_cnt_d = LAT_LOAD;
            state_d   = LAT;
         end
         LAT: begin
            if (lat_cnt_q == 3'd0) begin
               cowboy_d = dev_data;
               state_d  = CAP_H;
            end else begin
               lat_cnt_d = lat_cnt_q - 3'd1;
            end
         end
         CAP_H: begin
            horse_d  = dev_data;
            to_cnt_d = '0;
            state_d  = WAIT_RDY;
         end
         WAIT_RDY: begin
            if (dev_ready) begin
               gameover_d = dev_gameover;
               lostwon_d  = dev_lostwon;
               timeout_d  = 1'b0;
               state_d    = RESULT;
            end else if (to_cnt_q == TO_LAST) begin
               gameover_d = 1'b0;
               lostwon_d  = 1'b0;
               timeout_d  = 1'b1;
               state_d    = RESULT;
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
         end
         RESULT: begin
            if (res_ready) begin
               state_d = IDLE;
               // Aborted frames neither count as moves nor can end the game.
               if (!timeout_q) begin
                  if (count_q != 8'hFF) count_d = count_q + 8'd1;
                  if (gameover_q) game_over_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign cmd_ready    = (state_q == IDLE) && !game_over_q;
   assign dev_enter    = (state_q == SEND);
   assign dev_move     = dev_enter ? move_q : 3'd0;
   assign res_valid    = (state_q == RESULT);
   assign res_cowboy   = cowboy_q;
   assign res_horse    = horse_q;
   assign res_gameover = gameover_q;
   assign res_lostwon  = lostwon_q;
   assign res_timeout  = timeout_q;
   assign move_count   = count_q;

endmodule

// File: tb/tb_corral_host.sv
// Scoreboard bench for corral_host: a default-latency instance for most scenarios and
// a RESP_LATENCY=3 instance for the latency scenario.
module tb_corral_host;

   typedef struct packed {
      logic [3:0] cb;
      logic [3:0] hs;
      logic       go;
      logic       lw;
      logic       to;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       cmd_valid, cmd_ready, dev_enter, dev_ready, dev_gameover, dev_lostwon;
   logic       res_valid, res_ready, res_gameover, res_lostwon, res_timeout;
   logic [2:0] cmd_move, dev_move;
   logic [3:0] dev_data, res_cowboy, res_horse;
   logic [7:0] move_count;

   logic       l3_cmd_valid, l3_cmd_ready, l3_dev_enter, l3_dev_ready;
   logic       l3_res_valid, l3_res_gameover, l3_res_lostwon, l3_res_timeout;
   logic [2:0] l3_dev_move;
   logic [3:0] l3_dev_data, l3_res_cowboy, l3_res_horse;
   logic [7:0] l3_move_count;

   int   vectors = 0;
   int   miscompares = 0;
   int   exp_count = 0;
   exp_t sb_q[$];
   exp_t cur_exp;

   always #5 clock = ~clock;

   corral_host #(.RESP_LATENCY(1), .TIMEOUT(15)) dut (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_move(cmd_move),
      .dev_enter(dev_enter), .dev_move(dev_move), .dev_data(dev_data),
      .dev_ready(dev_ready), .dev_gameover(dev_gameover), .dev_lostwon(dev_lostwon),
      .res_valid(res_valid), .res_ready(res_ready), .res_cowboy(res_cowboy),
      .res_horse(res_horse), .res_gameover(res_gameover), .res_lostwon(res_lostwon),
      .res_timeout(res_timeout), .move_count(move_count)
   );

   corral_host #(.RESP_LATENCY(3), .TIMEOUT(15)) dut_l3 (
      .clock(clock), .reset_n(reset_n),
      .cmd_valid(l3_cmd_valid), .cmd_ready(l3_cmd_ready), .cmd_move(cmd_move),
      .dev_enter(l3_dev_enter), .dev_move(l3_dev_move), .dev_data(l3_dev_data),
      .dev_ready(l3_dev_ready), .dev_gameover(dev_gameover), .dev_lostwon(dev_lostwon),
      .res_valid(l3_res_valid), .res_ready(res_ready), .res_cowboy(l3_res_cowboy),
      .res_horse(l3_res_horse), .res_gameover(l3_res_gameover), .res_lostwon(l3_res_lostwon),
      .res_timeout(l3_res_timeout), .move_count(l3_move_count)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input logic [3:0] cb, input logic [3:0] hs,
                           input logic go, input logic lw, input logic to);
      exp_t e;
      e.cb = cb; e.hs = hs; e.go = go; e.lw = lw; e.to = to;
      sb_q.push_back(e);
   endtask

   // Runs one frame on the RESP_LATENCY=1 instance and checks it against the scoreboard.
   task automatic frame(input logic [2:0] mv, input logic [3:0] cb, input logic [3:0] hs,
                        input logic rdy, input logic go, input logic lw, input int exp_lat);
      int cyc;
      exp_t e;
      dev_ready = rdy; dev_gameover = go; dev_lostwon = lw;
      cyc = 0;
      while (cmd_ready !== 1'b1 && cyc < 20) begin
         @(posedge clock); #1; cyc++;
      end
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL cmd_ready_wait: got %b expected 1", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_move = mv;
      push_exp(cb, hs, rdy & go, rdy & lw, ~rdy);
      @(posedge clock); #1;
      cmd_valid = 1'b0; cmd_move = ~mv; dev_data = 4'hF;
      vectors++;
      if ({dev_enter, dev_move} !== {1'b1, mv}) begin
         miscompares++;
         $display("FAIL send_strobe: got enter=%b move=%b expected enter=1 move=%b",
                  dev_enter, dev_move, mv);
      end
      @(posedge clock); #1;
      vectors++;
      if ({dev_enter, dev_move} !== 4'b0) begin
         miscompares++;
         $display("FAIL enter_one_cycle: got enter=%b move=%b expected 0/000", dev_enter, dev_move);
      end
      dev_data = cb;
      @(posedge clock); #1;
      dev_data = hs;
      @(posedge clock); #1;
      dev_data = 4'h0;
      cyc = 3;
      while (res_valid !== 1'b1 && cyc < 100) begin
         @(posedge clock); #1; cyc++;
      end
      vectors++;
      if (cyc !== exp_lat) begin
         miscompares++;
         $display("FAIL frame_latency: got %0d edges expected %0d", cyc, exp_lat);
      end
      vectors++;
      if (sb_q.size() == 0) begin
         miscompares++;
         $display("FAIL scoreboard_empty: result with no expected entry");
      end else begin
         e = sb_q.pop_front();
         cur_exp = e;
         if ({res_cowboy, res_horse, res_gameover, res_lostwon, res_timeout} !== e) begin
            miscompares++;
            $display("FAIL result: got cb=%h hs=%h go=%b lw=%b to=%b expected cb=%h hs=%h go=%b lw=%b to=%b",
                     res_cowboy, res_horse, res_gameover, res_lostwon, res_timeout,
                     e.cb, e.hs, e.go, e.lw, e.to);
         end
      end
   endtask

   task automatic ack();
      res_ready = 1'b1;
      @(posedge clock); #1;
      res_ready = 1'b0;
      vectors++;
      if (res_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL ack_release: got res_valid=%b expected 0", res_valid);
      end
   endtask

   task automatic check_count(input string name);
      vectors++;
      if (move_count !== 8'(exp_count)) begin
         miscompares++;
         $display("FAIL %s: got move_count=%0d expected %0d", name, move_count, exp_count);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({dev_enter, dev_move, res_valid, res_cowboy, res_horse, res_gameover,
           res_lostwon, res_timeout, move_count} !== 27'd0) begin
         miscompares++;
         $display("FAIL reset_outputs: got enter=%b move=%b valid=%b cb=%h hs=%h go=%b lw=%b to=%b cnt=%0d expected all 0",
                  dev_enter, dev_move, res_valid, res_cowboy, res_horse, res_gameover,
                  res_lostwon, res_timeout, move_count);
      end
      @(negedge clock); @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock); #1;
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_basic();
      frame(3'b010, 4'h5, 4'hA, 1'b1, 1'b0, 1'b0, 4);
      ack();
      exp_count++;
      check_count("basic_count");
   endtask

   task automatic test_backpressure();
      int bad;
      frame(3'b101, 4'hC, 4'h3, 1'b1, 1'b0, 1'b1, 4);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         dev_data  = 4'($urandom);
         cmd_valid = i[0];
         cmd_move  = 3'($urandom);
         @(posedge clock); #1;
         if ({res_cowboy, res_horse, res_gameover, res_lostwon, res_timeout} !== cur_exp ||
             res_valid !== 1'b1 || cmd_ready !== 1'b0 || dev_enter !== 1'b0)
            bad++;
      end
      cmd_valid = 1'b0;
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad);
      end
      ack();
      exp_count++;
      check_count("backpressure_count");
      @(posedge clock); #1;
      vectors++;
      if ({cmd_ready, dev_enter} !== 2'b10) begin
         miscompares++;
         $display("FAIL backpressure_idle: got ready=%b enter=%b expected 1/0", cmd_ready, dev_enter);
      end
   endtask

   task automatic test_timeout();
      frame(3'b001, 4'h7, 4'h8, 1'b0, 1'b1, 1'b1, 3 + 15);
      ack();
      check_count("timeout_count");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         frame(3'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b0, 1'($urandom), 4);
         ack();
         exp_count++;
         check_count("b2b_count");
      end
   endtask

   task automatic test_latency();
      int cyc;
      exp_t e;
      l3_dev_ready = 1'b1; dev_gameover = 1'b0; dev_lostwon = 1'b0;
      l3_cmd_valid = 1'b1; cmd_move = 3'b110;
      push_exp(4'h3, 4'h6, 1'b0, 1'b0, 1'b0);
      @(posedge clock); #1;
      l3_cmd_valid = 1'b0; l3_dev_data = 4'hF;
      vectors++;
      if ({l3_dev_enter, l3_dev_move} !== 4'b1110) begin
         miscompares++;
         $display("FAIL l3_send: got enter=%b move=%b expected 1/110", l3_dev_enter, l3_dev_move);
      end
      @(posedge clock); #1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      l3_dev_data = 4'h3;
      @(posedge clock); #1;
      l3_dev_data = 4'h6;
      @(posedge clock); #1;
      l3_dev_data = 4'hF;
      cyc = 5;
      while (l3_res_valid !== 1'b1 && cyc < 100) begin
         @(posedge clock); #1; cyc++;
      end
      vectors++;
      if (cyc !== 6) begin
         miscompares++;
         $display("FAIL l3_latency: got %0d edges expected 6", cyc);
      end
      e = sb_q.pop_front();
      vectors++;
      if ({l3_res_cowboy, l3_res_horse, l3_res_gameover, l3_res_lostwon, l3_res_timeout} !== e) begin
         miscompares++;
         $display("FAIL l3_result: got cb=%h hs=%h to=%b expected cb=%h hs=%h to=%b",
                  l3_res_cowboy, l3_res_horse, l3_res_timeout, e.cb, e.hs, e.to);
      end
      res_ready = 1'b1;
      @(posedge clock); #1;
      res_ready = 1'b0;
      vectors++;
      if ({l3_res_valid, l3_move_count} !== {1'b0, 8'd1}) begin
         miscompares++;
         $display("FAIL l3_ack: got valid=%b cnt=%0d expected 0/1", l3_res_valid, l3_move_count);
      end
   endtask

   task automatic test_reset_midframe();
      dev_ready = 1'b1;
      cmd_valid = 1'b1; cmd_move = 3'b100;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b0;
      #1;
      exp_count = 0;
      vectors++;
      if ({dev_enter, res_valid, res_cowboy, res_horse, res_timeout, move_count} !== 19'd0) begin
         miscompares++;
         $display("FAIL midframe_reset: got enter=%b valid=%b cb=%h hs=%h to=%b cnt=%0d expected all 0",
                  dev_enter, res_valid, res_cowboy, res_horse, res_timeout, move_count);
      end
      @(negedge clock);
      reset_n = 1'b1;
      frame(3'b111, 4'h1, 4'hE, 1'b1, 1'b0, 1'b0, 4);
      ack();
      exp_count++;
      check_count("after_reset_count");
   endtask

   task automatic test_gameover();
      int bad;
      frame(3'b011, 4'h2, 4'h9, 1'b1, 1'b1, 1'b1, 4);
      ack();
      exp_count++;
      check_count("gameover_count");
      bad = 0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clock); #1;
         if (cmd_ready !== 1'b0 || dev_enter !== 1'b0) bad++;
      end
      cmd_valid = 1'b0;
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL gameover_lock: got %0d accepting cycles expected 0", bad);
      end
      check_count("gameover_final_count");
   endtask

   initial begin
      cmd_valid = 1'b0; cmd_move = 3'd0; dev_data = 4'd0; dev_ready = 1'b0;
      dev_gameover = 1'b0; dev_lostwon = 1'b0; res_ready = 1'b0;
      l3_cmd_valid = 1'b0; l3_dev_data = 4'd0; l3_dev_ready = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_timeout();
      test_back_to_back();
      test_latency();
      test_reset_midframe();
      test_gameover();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
